// File: rtl/vend_fsm_param.sv
// Parametrised vending controller with greedy one-coin-per-second change.
// Optional coin overpay rejection is enabled by defining VEND_OVERPAY_REJECT_EN.
module vend_fsm_param #(
  parameter int                   N_ITEMS     = 3,
  parameter int                   W           = 10,
  parameter logic [N_ITEMS*W-1:0] PRICES      = {10'd110, 10'd70, 10'd30},
  parameter int                   COIN0       = 20,
  parameter int                   COIN1       = 50,
  parameter int                   COIN2       = 100,
  parameter int                   CHG0        = 10,
  parameter int                   CHG1        = 50,
  parameter int                   CHG2        = 100,
  parameter int                   TIMEOUT_S   = 10,
  parameter int                   VEND_S      = 2,
  parameter int                   REFUND_S    = 2,
  parameter int                   MAX_OVERPAY = 50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1hz,
  input  logic [N_ITEMS-1:0] sel,
  input  logic [2:0]         coin,
  input  logic               cancel,
  output logic [1:0]         state,
  output logic [W-1:0]       credit,
  output logic [W-1:0]       price,
  output logic [N_ITEMS-1:0] item_oh,
  output logic               vend_on,
  output logic [2:0]         chg_coin,
  output logic               coin_reject,
  output logic [3:0]         secs
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_COIN   = 2'd1;
  localparam logic [1:0] S_VEND   = 2'd2;
  localparam logic [1:0] S_CHANGE = 2'd3;
  localparam int         WX       = W + 1;

`ifdef VEND_OVERPAY_REJECT_EN
  localparam logic REJECT_EN = 1'b1;
`else
  localparam logic REJECT_EN = 1'b0;
`endif

  function automatic logic [N_ITEMS-1:0] lowest_bit(input logic [N_ITEMS-1:0] v);
    logic [N_ITEMS-1:0] res;
    res = '0;
    for (int i = N_ITEMS - 1; i >= 0; i--) begin
      if (v[i]) begin
        res    = '0;
        res[i] = 1'b1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [W-1:0] price_of(input logic [N_ITEMS-1:0] oh);
    logic [W-1:0] p;
    p = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (oh[i]) begin
        p = PRICES[i*W +: W];
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

  // Greedy change: largest change coin not exceeding the remaining credit.
  function automatic logic [2:0] chg_pick(input logic [W-1:0] c);
    if (c >= W'(CHG2)) begin
      return 3'b100;
    end else if (c >= W'(CHG1)) begin
      return 3'b010;
    end else if (c >= W'(CHG0)) begin
      return 3'b001;
    end else begin
      return 3'b000;
    end
  endfunction

  function automatic logic [W-1:0] chg_value(input logic [2:0] pick);
    case (pick)
      3'b100:  return W'(CHG2);
      3'b010:  return W'(CHG1);
      3'b001:  return W'(CHG0);
      default: return '0;
    endcase
  endfunction

  logic [1:0]         state_q, state_d;
  logic [W-1:0]       credit_q, credit_d;
  logic [W-1:0]       price_q, price_d;
  logic [N_ITEMS-1:0] item_q, item_d;
  logic [3:0]         secs_q, secs_d;
  logic [2:0]         chg_q, chg_d;
  logic               rej_q, rej_d;
  logic               vend_q;
  logic [W-1:0]       coin_val_s;
  logic               coin_any_s;
  logic               coin_ok_s;

  // Coin value decode with fixed priority and optional overpay limit.
  always_comb begin
    coin_any_s = |coin;
    if (coin[0]) begin
      coin_val_s = W'(COIN0);
    end else if (coin[1]) begin
      coin_val_s = W'(COIN1);
    end else if (coin[2]) begin
      coin_val_s = W'(COIN2);
    end else begin
      coin_val_s = '0;
    end
    coin_ok_s = !REJECT_EN ||
                (({1'b0, credit_q} + {1'b0, coin_val_s}) <= ({1'b0, price_q} + WX'(MAX_OVERPAY)));
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    price_d  = price_q;
    item_d   = item_q;
    secs_d   = secs_q;
    chg_d    = 3'b000;
    rej_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        credit_d = '0;
        if (sel != '0) begin
          item_d  = lowest_bit(sel);
          price_d = price_of(lowest_bit(sel));
          secs_d  = 4'd0;
          state_d = S_COIN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COIN: begin
        if (credit_q >= price_q) begin
          state_d = S_VEND;
          secs_d  = 4'd0;
        end else if (cancel) begin
          state_d = S_CHANGE;
          secs_d  = 4'd0;
        end else if (coin_any_s && coin_ok_s) begin
          credit_d = credit_q + coin_val_s;
          secs_d   = 4'd0;
        end else begin
          // A rejected coin leaves the timeout running.
          rej_d = coin_any_s;
          if (tick_1hz) begin
            if (secs_q == 4'(TIMEOUT_S - 1)) begin
              state_d = S_CHANGE;
              secs_d  = 4'd0;
            end else begin
              secs_d = secs_q + 4'd1;
            end
          end else begin
            secs_d = secs_q;
          end
        end
      end
      S_VEND: begin
        if (tick_1hz) begin
          if (secs_q == 4'(VEND_S - 1)) begin
            state_d  = S_CHANGE;
            credit_d = credit_q - price_q;
            secs_d   = 4'd0;
          end else begin
            secs_d = secs_q + 4'd1;
          end
        end else begin
          secs_d = secs_q;
        end
      end
      S_CHANGE: begin
        if (tick_1hz) begin
          if (credit_q != '0) begin
            chg_d    = chg_pick(credit_q);
            credit_d = credit_q - chg_value(chg_pick(credit_q));
          end else begin
            credit_d = credit_q;
          end
          if (secs_q < 4'(REFUND_S)) begin
            secs_d = secs_q + 4'd1;
          end else begin
            secs_d = secs_q;
          end
        end else begin
          secs_d = secs_q;
        end
        if ((credit_q == '0) && (secs_q >= 4'(REFUND_S)) && (sel == '0)) begin
          state_d = S_IDLE;
          item_d  = '0;
          price_d = '0;
          secs_d  = 4'd0;
        end else begin
          state_d = state_d;
        end
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
        price_d  = '0;
        item_d   = '0;
        secs_d   = 4'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      price_q  <= '0;
      item_q   <= '0;
      secs_q   <= 4'd0;
      chg_q    <= 3'b000;
      rej_q    <= 1'b0;
      vend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      price_q  <= price_d;
      item_q   <= item_d;
      secs_q   <= secs_d;
      chg_q    <= chg_d;
      rej_q    <= rej_d;
      vend_q   <= (state_d == S_VEND);
    end
  end

  assign state       = state_q;
  assign credit      = credit_q;
  assign price       = price_q;
  assign item_oh     = item_q;
  assign vend_on     = vend_q;
  assign chg_coin    = chg_q;
  assign coin_reject = rej_q;
  assign secs        = secs_q;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Directed self-checking bench for vend_fsm_param with default parameters.
module tb_vend_fsm_param;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic [2:0] sel = 3'b000;
  logic [2:0] coin = 3'b000;
  logic       cancel = 1'b0;
  logic [1:0] state;
  logic [9:0] credit;
  logic [9:0] price;
  logic [2:0] item_oh;
  logic       vend_on;
  logic [2:0] chg_coin;
  logic       coin_reject;
  logic [3:0] secs;
  int checks = 0;
  int errors = 0;

  vend_fsm_param dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .sel(sel), .coin(coin), .cancel(cancel),
    .state(state), .credit(credit), .price(price), .item_oh(item_oh), .vend_on(vend_on),
    .chg_coin(chg_coin), .coin_reject(coin_reject), .secs(secs)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_step();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic drain();
    sel = 3'b000;
    for (int i = 0; i < 60 && state !== 2'd0; i++) begin
      tick_1hz = (i % 2 == 0);
      step();
      tick_1hz = 1'b0;
    end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL drain_idle state=%0d exp=0", state); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if (credit !== 10'd0) begin errors++; $display("FAIL rst_credit got=%0d exp=0", credit); end
    checks++; if (price !== 10'd0 || item_oh !== 3'b000) begin errors++; $display("FAIL rst_latch price=%0d item=%b exp 0", price, item_oh); end
    checks++; if (vend_on !== 1'b0 || chg_coin !== 3'b000 || coin_reject !== 1'b0 || secs !== 4'd0) begin
      errors++; $display("FAIL rst_outs vend=%b chg=%b rej=%b secs=%0d exp 0", vend_on, chg_coin, coin_reject, secs);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_vend_change();
    sel = 3'b010;
    step();
    checks++; if (state !== 2'd1 || item_oh !== 3'b010) begin errors++; $display("FAIL vc_sel state=%0d item=%b exp 1/010", state, item_oh); end
    checks++; if (price !== 10'd70) begin errors++; $display("FAIL vc_price got=%0d exp=70", price); end
    coin = 3'b100; step(); coin = 3'b000;
    checks++; if (credit !== 10'd100 || state !== 2'd1) begin errors++; $display("FAIL vc_coin credit=%0d state=%0d exp 100/1", credit, state); end
    step();
    checks++; if (state !== 2'd2 || vend_on !== 1'b1) begin errors++; $display("FAIL vc_vend state=%0d vend=%b exp 2/1", state, vend_on); end
    tick_step();
    checks++; if (state !== 2'd2 || secs !== 4'd1) begin errors++; $display("FAIL vc_vend1 state=%0d secs=%0d exp 2/1", state, secs); end
    tick_step();
    checks++; if (state !== 2'd3 || credit !== 10'd30 || vend_on !== 1'b0) begin
      errors++; $display("FAIL vc_change state=%0d credit=%0d vend=%b exp 3/30/0", state, credit, vend_on);
    end
    checks++; if (item_oh !== 3'b010) begin errors++; $display("FAIL vc_item_hold got=%b exp=010", item_oh); end
    tick_step();
    checks++; if (chg_coin !== 3'b001 || credit !== 10'd20) begin errors++; $display("FAIL vc_chg1 chg=%b credit=%0d exp 001/20", chg_coin, credit); end
    step();
    checks++; if (chg_coin !== 3'b000) begin errors++; $display("FAIL vc_chg_pulse got=%b exp=000", chg_coin); end
    tick_step();
    checks++; if (credit !== 10'd10) begin errors++; $display("FAIL vc_chg2 credit=%0d exp=10", credit); end
    tick_step();
    checks++; if (credit !== 10'd0 || chg_coin !== 3'b001) begin errors++; $display("FAIL vc_chg3 credit=%0d chg=%b exp 0/001", credit, chg_coin); end
    step();
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL vc_hold_sel state=%0d exp=3", state); end
    sel = 3'b000;
    step();
    checks++; if (state !== 2'd0 || item_oh !== 3'b000 || price !== 10'd0) begin
      errors++; $display("FAIL vc_exit state=%0d item=%b price=%0d exp 0/000/0", state, item_oh, price);
    end
  endtask

  task automatic test_cancel();
    sel = 3'b100;
    step();
    sel = 3'b000;
    checks++; if (price !== 10'd110 || item_oh !== 3'b100) begin errors++; $display("FAIL cn_sel price=%0d item=%b exp 110/100", price, item_oh); end
    coin = 3'b010; step(); coin = 3'b000;
    coin = 3'b010; step(); coin = 3'b000;
    checks++; if (credit !== 10'd100 || state !== 2'd1) begin errors++; $display("FAIL cn_credit credit=%0d state=%0d exp 100/1", credit, state); end
    cancel = 1'b1; step(); cancel = 1'b0;
    checks++; if (state !== 2'd3 || credit !== 10'd100) begin errors++; $display("FAIL cn_change state=%0d credit=%0d exp 3/100", state, credit); end
    tick_step();
    checks++; if (chg_coin !== 3'b100 || credit !== 10'd0) begin errors++; $display("FAIL cn_chg chg=%b credit=%0d exp 100/0", chg_coin, credit); end
    tick_step();
    checks++; if (state !== 2'd3 || secs !== 4'd2) begin errors++; $display("FAIL cn_min state=%0d secs=%0d exp 3/2", state, secs); end
    step();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL cn_idle state=%0d exp=0", state); end
  endtask

  task automatic test_timeout();
    sel = 3'b001; step(); sel = 3'b000;
    repeat (9) tick_step();
    checks++; if (state !== 2'd1 || secs !== 4'd9) begin errors++; $display("FAIL to_9 state=%0d secs=%0d exp 1/9", state, secs); end
    tick_step();
    checks++; if (state !== 2'd3 || credit !== 10'd0 || secs !== 4'd0) begin
      errors++; $display("FAIL to_10 state=%0d credit=%0d secs=%0d exp 3/0/0", state, credit, secs);
    end
    drain();
    sel = 3'b001; step(); sel = 3'b000;
    repeat (8) tick_step();
    coin = 3'b001; tick_1hz = 1'b1; step(); coin = 3'b000; tick_1hz = 1'b0;
    checks++; if (state !== 2'd1 || credit !== 10'd20 || secs !== 4'd0) begin
      errors++; $display("FAIL to_restart state=%0d credit=%0d secs=%0d exp 1/20/0", state, credit, secs);
    end
    tick_step();
    checks++; if (state !== 2'd1 || secs !== 4'd1) begin errors++; $display("FAIL to_after state=%0d secs=%0d exp 1/1", state, secs); end
    cancel = 1'b1; step(); cancel = 1'b0;
    drain();
  endtask

  task automatic test_multi_coin_overpay();
    sel = 3'b001; step(); sel = 3'b000;
    coin = 3'b011; step(); coin = 3'b000;
    checks++; if (credit !== 10'd20 || state !== 2'd1) begin errors++; $display("FAIL mc_credit credit=%0d state=%0d exp 20/1", credit, state); end
    coin = 3'b100; step(); coin = 3'b000;
`ifdef VEND_OVERPAY_REJECT_EN
    checks++; if (credit !== 10'd20 || coin_reject !== 1'b1) begin errors++; $display("FAIL op_reject credit=%0d rej=%b exp 20/1", credit, coin_reject); end
    step();
    checks++; if (coin_reject !== 1'b0 || state !== 2'd1) begin errors++; $display("FAIL op_pulse rej=%b state=%0d exp 0/1", coin_reject, state); end
    cancel = 1'b1; step(); cancel = 1'b0;
`else
    checks++; if (credit !== 10'd120 || coin_reject !== 1'b0) begin errors++; $display("FAIL op_accept credit=%0d rej=%b exp 120/0", credit, coin_reject); end
    step();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL op_vend state=%0d exp=2", state); end
    tick_step(); tick_step();
    checks++; if (state !== 2'd3 || credit !== 10'd90) begin errors++; $display("FAIL op_change state=%0d credit=%0d exp 3/90", state, credit); end
    tick_step();
    checks++; if (chg_coin !== 3'b010 || credit !== 10'd40) begin errors++; $display("FAIL op_chg50 chg=%b credit=%0d exp 010/40", chg_coin, credit); end
`endif
    drain();
  endtask

  task automatic test_reset_midop();
    sel = 3'b011; step(); sel = 3'b000;
    checks++; if (item_oh !== 3'b001 || price !== 10'd30) begin errors++; $display("FAIL rm_sel item=%b price=%0d exp 001/30", item_oh, price); end
    coin = 3'b010; step(); coin = 3'b000;
    step();
    checks++; if (state !== 2'd2 || vend_on !== 1'b1) begin errors++; $display("FAIL rm_vend state=%0d vend=%b exp 2/1", state, vend_on); end
    rst = 1'b1; step();
    checks++; if (state !== 2'd0 || credit !== 10'd0 || vend_on !== 1'b0) begin
      errors++; $display("FAIL rm_reset state=%0d credit=%0d vend=%b exp 0/0/0", state, credit, vend_on);
    end
    rst = 1'b0; step();
    checks++; if (state !== 2'd0 || chg_coin !== 3'b000) begin errors++; $display("FAIL rm_after state=%0d chg=%b exp 0/000", state, chg_coin); end
  endtask

  initial begin
    test_reset();
    test_vend_change();
    test_cancel();
    test_timeout();
    test_multi_coin_overpay();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
